// File: rtl/mdu_pkg.sv
// Shared types and small decode helpers for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_t;

    // MULT and DIV treat their operands as two's complement.
    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    // Bit 1 of the opcode separates the divide pair from the multiply pair.
    function automatic logic op_is_div(input mdu_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation: y = neg ? -a : a.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// A single 2*WIDTH accumulator is shared: shift-add for multiply,
// restoring division ({remainder, quotient}) for divide.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    mdu_state_t         state_q, state_d;
    mdu_op_t            op_q, op_d;
    logic               neg_res_q, neg_res_d;   // negate product / quotient
    logic               neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
    logic               fix_stage_q, fix_stage_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    mdu_op_t            op_in;
    logic [WIDTH-1:0]   src_arr [2];
    logic [WIDTH-1:0]   mag [2];
    logic [1:0]         src_neg;

    assign op_in      = mdu_op_t'(op);
    assign src_arr[0] = src_a;
    assign src_arr[1] = src_b;

    // Operand magnitudes; unsigned ops pass straight through.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mag
        assign src_neg[gi] = op_is_signed(op_in) & src_arr[gi][WIDTH-1];
        mdu_negate #(.W(WIDTH)) u_mag (
            .neg (src_neg[gi]),
            .a   (src_arr[gi]),
            .y   (mag[gi])
        );
    end

    // One shift-add step: conditionally add the multiplicand to the upper half, shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    // The partial remainder is always below twice the divisor, so the difference fits WIDTH bits.
    logic [WIDTH:0]     div_rem_s;
    logic [WIDTH-1:0]   div_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_rem_s = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_rem_s[WIDTH-1:0] - opnd_q;
    assign div_ge    = div_rem_s >= {1'b0, opnd_q};
    assign div_next  = {(div_ge ? div_trial : div_rem_s[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    // Sign correction: full-width negate for products, per-half for quotient/remainder.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] fix_val;

    mdu_negate #(.W(2*WIDTH)) u_fix_prod (.neg(neg_res_q), .a(acc_q),                     .y(prod_fix));
    mdu_negate #(.W(WIDTH))   u_fix_quo  (.neg(neg_res_q), .a(acc_q[WIDTH-1:0]),          .y(quo_fix));
    mdu_negate #(.W(WIDTH))   u_fix_rem  (.neg(neg_rem_q), .a(acc_q[2*WIDTH-1:WIDTH]),    .y(rem_fix));

    assign fix_val = op_is_div(op_q) ? {rem_fix, quo_fix} : prod_fix;

    // Next-state and datapath control; FIX registers the corrected result, then commits it.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        fix_stage_d = fix_stage_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        dbz_d       = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (hilo_we) begin
                    if (hilo_sel) hi_d = hilo_wd;
                    else          lo_d = hilo_wd;
                end
                if (start) begin
                    if (op_is_div(op_in) && (src_b == '0)) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        op_d        = op_in;
                        neg_res_d   = src_neg[0] ^ src_neg[1];
                        neg_rem_d   = op_is_div(op_in) & src_neg[0];
                        opnd_d      = op_is_div(op_in) ? mag[1] : mag[0];
                        acc_d       = {{WIDTH{1'b0}}, (op_is_div(op_in) ? mag[0] : mag[1])};
                        cnt_d       = CNT_LOAD;
                        fix_stage_d = 1'b0;
                        state_d     = MDU_CALC;
                    end
                end
            end
            MDU_CALC: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = MDU_FIX;
            end
            MDU_FIX: begin
                if (!fix_stage_q) begin
                    acc_d       = fix_val;
                    fix_stage_d = 1'b1;
                end else begin
                    hi_d    = acc_q[2*WIDTH-1:WIDTH];
                    lo_d    = acc_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MDU_IDLE;
            op_q        <= MDU_MULT;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            fix_stage_q <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            fix_stage_q <= fix_stage_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == MDU_CALC) || (state_q == MDU_FIX);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
